// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcodes, IEEE-754 single field constants, sequencer state codes, flag bit positions.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [7:0] FP_EXP_ALL1 = 8'hFF;
  localparam logic [7:0] FP_EXP_ZERO = 8'h00;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Flag vector is {nan, inf, zero, sign}
  localparam int unsigned FLAG_NAN  = 3;
  localparam int unsigned FLAG_INF  = 2;
  localparam int unsigned FLAG_ZERO = 1;
  localparam int unsigned FLAG_SIGN = 0;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic sign;
  } fp_flags_t;

endpackage

// File: rtl/fpu_result_classifier.sv
// Combinational IEEE-754 single classifier: value -> {nan, inf, zero, sign}.
// Denormals report none of nan/inf/zero; sign is always bit 31.
module fpu_result_classifier
  import fpu_pkg::*;
(
  input  logic [31:0] value_i,
  output logic [3:0]  flags_o
);

  logic [7:0]  exp_c;
  logic [22:0] man_c;
  logic        man_zero_c;

  assign exp_c      = value_i[30:23];
  assign man_c      = value_i[22:0];
  assign man_zero_c = (man_c == 23'd0);

  always_comb begin
    flags_o            = 4'b0000;
    flags_o[FLAG_NAN]  = (exp_c == FP_EXP_ALL1) && !man_zero_c;
    flags_o[FLAG_INF]  = (exp_c == FP_EXP_ALL1) &&  man_zero_c;
    flags_o[FLAG_ZERO] = (exp_c == FP_EXP_ZERO) &&  man_zero_c;
    flags_o[FLAG_SIGN] = value_i[31];
  end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Drives a combinational FPU from a tagged command channel: register operands, wait a settle
// window, capture and classify the result, return it on a valid/ready response channel.
module fpu_cmd_sequencer
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OP_WIDTH      = 2,
  parameter int TAG_W         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_op1,
  input  logic [DATA_WIDTH-1:0] cmd_op2,
  input  logic [OP_WIDTH-1:0]   cmd_opcode,
  input  logic [TAG_W-1:0]      cmd_tag,
  output logic [DATA_WIDTH-1:0] fpu_operand1,
  output logic [DATA_WIDTH-1:0] fpu_operand2,
  output logic [OP_WIDTH-1:0]   fpu_opcode,
  input  logic [DATA_WIDTH-1:0] fpu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [3:0]            rsp_flags,
  output logic                  busy,
  output logic [15:0]           done_count
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("fpu_cmd_sequencer: SETTLE_CYCLES must be within 1..15");
    end
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("fpu_cmd_sequencer: classifier expects IEEE-754 single (DATA_WIDTH=32)");
    end
  endgenerate

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [OP_WIDTH-1:0]   opc_q, opc_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]      rsp_tag_q, rsp_tag_d;
  logic [3:0]            rsp_flags_q, rsp_flags_d;
  logic [15:0]           done_count_q, done_count_d;
  logic [3:0]            flags_c;

  fpu_result_classifier u_classifier (
    .value_i (fpu_result[31:0]),
    .flags_o (flags_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    opc_d        = opc_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_flags_d  = rsp_flags_q;
    done_count_d = done_count_q;

    case (state_q)
      ST_IDLE: begin
        // Command fields are only sampled on the accepting edge
        if (cmd_valid) begin
          op1_d   = cmd_op1;
          op2_d   = cmd_op2;
          opc_d   = cmd_opcode;
          tag_d   = cmd_tag;
          cnt_d   = SETTLE_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = fpu_result;
          rsp_flags_d  = flags_c;
          rsp_tag_d    = tag_q;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          done_count_d = done_count_q + 16'd1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      op1_q        <= '0;
      op2_q        <= '0;
      opc_q        <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_flags_q  <= 4'd0;
      done_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      opc_q        <= opc_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_flags_q  <= rsp_flags_d;
      done_count_q <= done_count_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign fpu_operand1 = op1_q;
  assign fpu_operand2 = op2_q;
  assign fpu_opcode   = opc_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_tag      = rsp_tag_q;
  assign rsp_flags    = rsp_flags_q;
  assign done_count   = done_count_q;

endmodule
